// File: rtl/gate_truth_scanner.sv
// gate_truth_scanner: steps the basic-gate block through all four {A,B}
// combinations, waits SETTLE_CYCLES per combination, and captures the eight
// gate outputs into a 32-bit truth table (slot i = bits [8i+7:8i], i = {A,B}).
// Optional golden-model checker: define GATE_SCAN_CHECK_EN to compile in the
// per-gate sticky mismatch flags; otherwise mismatch/error are tied to 0.
module gate_truth_scanner #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        a_out,
  output logic        b_out,
  input  logic [7:0]  gate_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] table_out,
  output logic [7:0]  mismatch,
  output logic        error
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned GATES   = 8;
  localparam int unsigned TAB_W   = 32;
  localparam int unsigned IDX_W   = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(3);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               busy_n, done_n;
  logic [TAB_W-1:0]   table_n;
  logic               clr_mismatch;
  logic               do_sample;

  // Combination index drives the gate block directly from its register.
  assign a_out = idx[1];
  assign b_out = idx[0];

  // State, index, counter, table and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      busy      <= busy_n;
      done      <= done_n;
      table_out <= table_n;
    end
  end

  // Next-state logic: start accepted only from IDLE/DONE; one capture per SAMPLE.
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    cnt_n        = cnt;
    busy_n       = busy;
    done_n       = done;
    table_n      = table_out;
    clr_mismatch = 1'b0;
    do_sample    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n      = DRIVE;
          idx_n        = '0;
          cnt_n        = '0;
          busy_n       = 1'b1;
          done_n       = 1'b0;
          clr_mismatch = 1'b1;
        end
      end
      DRIVE: begin
        cnt_n = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          state_n = SAMPLE;
        end
      end
      SAMPLE: begin
        do_sample = 1'b1;
        table_n[{idx, 3'b000} +: GATES] = gate_in;
        if (idx == IDX_LAST) begin
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          state_n = DRIVE;
          idx_n   = idx + IDX_W'(1);
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef GATE_SCAN_CHECK_EN
  // Ideal Boolean outputs for the current combination, in gate_in bit order.
  function automatic logic [GATES-1:0] golden(input logic a, input logic b);
    golden = {a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
  endfunction

  logic [GATES-1:0] mismatch_q;

  // Sticky per-gate error flags, cleared when a new scan is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch_q <= '0;
    end else if (clr_mismatch) begin
      mismatch_q <= '0;
    end else if (do_sample) begin
      mismatch_q <= mismatch_q | (gate_in ^ golden(idx[1], idx[0]));
    end
  end

  assign mismatch = mismatch_q;
`else
  logic unused_ok;
  assign unused_ok = clr_mismatch ^ do_sample;
  assign mismatch  = '0;
`endif

  assign error = |mismatch;

endmodule

// File: tb/tb_gate_truth_scanner.sv
// tb_gate_truth_scanner: randomized and directed scans of two scanner
// instances (settle 2 and settle 1) against fault-injectable gate models.
module tb_gate_truth_scanner;

  logic        clk = 1'b0;
  logic        rst0, rst1, start0, start1;
  logic        a0, b0, a1, b1;
  logic [7:0]  gate0, gate1;
  logic        busy0, busy1, done0, done1, err0, err1;
  logic [31:0] tab0, tab1;
  logic [7:0]  mm0, mm1;
  logic [7:0]  s0_0 = 8'h00, s1_0 = 8'h00, s0_1 = 8'h00, s1_1 = 8'h00;
  logic [31:0] prev_tab [2];

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Ideal gate outputs, written gate by gate from their definitions.
  function automatic logic [7:0] ideal(input logic a, input logic b);
    logic [7:0] g;
    g[0] = a && b;
    g[1] = a || b;
    g[2] = !a;
    g[3] = !(a && b);
    g[4] = !(a || b);
    g[5] = a != b;
    g[6] = a == b;
    g[7] = a;
    return g;
  endfunction

  // Faulty gate block: stuck-at-0 mask s0, stuck-at-1 mask s1.
  function automatic logic [7:0] faulty(input logic a, input logic b,
                                        input logic [7:0] s0, input logic [7:0] s1);
    return (ideal(a, b) | s1) & ~s0;
  endfunction

  assign gate0 = faulty(a0, b0, s0_0, s1_0);
  assign gate1 = faulty(a1, b1, s0_1, s1_1);

  gate_truth_scanner #(.SETTLE_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst0), .start(start0), .a_out(a0), .b_out(b0),
    .gate_in(gate0), .busy(busy0), .done(done0), .table_out(tab0),
    .mismatch(mm0), .error(err0));

  gate_truth_scanner #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst1), .start(start1), .a_out(a1), .b_out(b1),
    .gate_in(gate1), .busy(busy1), .done(done1), .table_out(tab1),
    .mismatch(mm1), .error(err1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected table: each slot is the faulty block's response to that {A,B}.
  function automatic logic [31:0] model_table(input logic [7:0] s0, input logic [7:0] s1);
    logic [31:0] t = '0;
    for (int i = 0; i < 4; i++)
      t = t | (32'(faulty(i / 2 == 1, i % 2 == 1, s0, s1)) << (8 * i));
    return t;
  endfunction

  function automatic logic [7:0] model_mm(input logic [7:0] s0, input logic [7:0] s1);
    logic [7:0] m = '0;
`ifdef GATE_SCAN_CHECK_EN
    for (int i = 0; i < 4; i++)
      m = m | (faulty(i / 2 == 1, i % 2 == 1, s0, s1) ^ ideal(i / 2 == 1, i % 2 == 1));
`else
    m = s0 & s1 & 8'h00;
`endif
    return m;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 1) start1 = v; else start0 = v;
  endtask

  task automatic set_rst(input int sel, input logic v);
    if (sel == 1) rst1 = v; else rst0 = v;
  endtask

  task automatic check_outputs(input int sel, input string tag, input logic busy_e,
                               input logic done_e, input logic [1:0] ab_e);
    check({tag, ".busy"}, 32'(sel == 1 ? busy1 : busy0), 32'(busy_e));
    check({tag, ".done"}, 32'(sel == 1 ? done1 : done0), 32'(done_e));
    check({tag, ".ab"}, 32'(sel == 1 ? {a1, b1} : {a0, b0}), 32'(ab_e));
  endtask

  task automatic check_reset_state(input int sel, input string tag);
    check_outputs(sel, tag, 1'b0, 1'b0, 2'b00);
    check({tag, ".table"}, sel == 1 ? tab1 : tab0, 32'h0);
    check({tag, ".mismatch"}, 32'(sel == 1 ? mm1 : mm0), 32'h0);
    check({tag, ".error"}, 32'(sel == 1 ? err1 : err0), 32'h0);
  endtask

  // One scan: start pulse, per-cycle checks, optional ignored starts and abort.
  task automatic run_scan(input int sel, input logic [7:0] s0, input logic [7:0] s1,
                          input int p1, input int p2, input int abort_at);
    int s     = (sel == 1) ? 1 : 2;
    int total = 4 * (s + 1);
    int slot;
    logic [31:0] exp_tab = model_table(s0, s1);
    logic [7:0]  exp_mm  = model_mm(s0, s1);
    if (sel == 1) begin s0_1 = s0; s1_1 = s1; end
    else begin s0_0 = s0; s1_0 = s1; end
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    set_start(sel, 1'b0);
    check_outputs(sel, "accept", 1'b1, 1'b0, 2'b00);
    check("accept.mismatch_clr", 32'(sel == 1 ? mm1 : mm0), 32'h0);
    check("accept.table_kept", sel == 1 ? tab1 : tab0, prev_tab[sel]);
    for (int k = 1; k <= total; k++) begin
      if (k == abort_at) begin
        set_rst(sel, 1'b1);
        #1;
        check_reset_state(sel, "abort");
        set_rst(sel, 1'b0);
        prev_tab[sel] = '0;
        return;
      end
      if (k == p1 || k == p2) set_start(sel, 1'b1);
      @(posedge clk); #1;
      set_start(sel, 1'b0);
      slot = k / (s + 1);
      if (slot > 3) slot = 3;
      check_outputs(sel, "scan", k < total, k == total, 2'(slot));
    end
    check("end.table", sel == 1 ? tab1 : tab0, exp_tab);
    check("end.mismatch", 32'(sel == 1 ? mm1 : mm0), 32'(exp_mm));
    check("end.error", 32'(sel == 1 ? err1 : err0), 32'(exp_mm != 8'h00));
    prev_tab[sel] = exp_tab;
    @(posedge clk); #1;
    check_outputs(sel, "hold", 1'b0, 1'b1, 2'b11);
  endtask

  initial begin
    int sel, total, p1, p2, ab;
    logic [7:0] r0, r1;
    rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
    prev_tab[0] = '0; prev_tab[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst0 = 1'b0; rst1 = 1'b0;
    check_reset_state(0, "reset0");
    check_reset_state(1, "reset1");

    // Ideal scan with stray starts at cycles 3 and 7.
    run_scan(0, 8'h00, 8'h00, 3, 7, 0);
    check("ideal.table", tab0, 32'hC3AA2E5C);
    // NOT stuck at 0, then restart from DONE with ideal gates.
    run_scan(0, 8'h04, 8'h00, 0, 0, 0);
    check("notsa0.table", tab0, 32'hC3AA2A58);
    run_scan(0, 8'h00, 8'h00, 0, 0, 0);
    check("restart.table", tab0, 32'hC3AA2E5C);
    // Reset during slot-2 drive, then a normal scan.
    run_scan(0, 8'h00, 8'h00, 0, 0, 8);
    run_scan(0, 8'h00, 8'h00, 0, 0, 0);
    // Settle of one cycle.
    run_scan(1, 8'h00, 8'h00, 0, 0, 0);
    check("s1.table", tab1, 32'hC3AA2E5C);

    // Randomized faults, stray starts and aborts.
    for (int it = 0; it < 24; it++) begin
      sel   = int'($urandom_range(0, 1));
      total = (sel == 1) ? 8 : 12;
      r0    = 8'($urandom & $urandom & $urandom);
      r1    = 8'($urandom & $urandom & $urandom) & ~r0;
      p1    = int'($urandom_range(0, total));
      p2    = int'($urandom_range(0, total));
      ab    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, total)) : 0;
      run_scan(sel, r0, r1, p1, p2, ab);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
